// File: rtl/whac_display_pkg.sv
// Shared types and constants for the countdown display datapath.
package whac_display_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      UPDATE  = 2'd2
   } state_t;

   localparam logic [6:0]  SEG_BLANK     = 7'b1111111;
   localparam int unsigned MS_PER_SECOND = 1000;
   localparam int unsigned DABBLE_STEPS  = 10;

   localparam int unsigned BIN_W      = 10;
   localparam int unsigned BCD_DIGITS = 3;
   localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
   localparam int unsigned DD_W       = BCD_W + BIN_W;
   localparam int unsigned ITER_W     = 4;
   localparam int unsigned SEG_W      = 7;

   // Any code above 9 renders as an unlit digit.
   localparam logic [3:0] DIGIT_OFF = 4'hF;

   // One double-dabble step on {bcd, bin}: add 3 to nibbles >= 5, then shift left.
   function automatic logic [DD_W-1:0] dabble_step(input logic [DD_W-1:0] v);
      logic [DD_W-1:0] t;
      t = v;
      for (int d = 0; d < int'(BCD_DIGITS); d++) begin
         if (t[BIN_W + 4*d +: 4] >= 4'd5)
            t[BIN_W + 4*d +: 4] = t[BIN_W + 4*d +: 4] + 4'd3;
      end
      return {t[DD_W-2:0], 1'b0};
   endfunction

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to active-low {g,f,e,d,c,b,a} segment pattern; codes above 9 go dark.
module seg7_decoder
   import whac_display_pkg::*;
(
   input  logic [3:0]       digit,
   output logic [SEG_W-1:0] seg_c
);

   always_comb begin
      seg_c = SEG_BLANK;
      case (digit)
         4'd0: seg_c = 7'b1000000;
         4'd1: seg_c = 7'b1111001;
         4'd2: seg_c = 7'b0100100;
         4'd3: seg_c = 7'b0110000;
         4'd4: seg_c = 7'b0011001;
         4'd5: seg_c = 7'b0010010;
         4'd6: seg_c = 7'b0000010;
         4'd7: seg_c = 7'b1111000;
         4'd8: seg_c = 7'b0000000;
         4'd9: seg_c = 7'b0010000;
         default: seg_c = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/countdown_display.sv
// Samples the game timer every REFRESH_CLKS clocks, converts seconds and remaining
// milliseconds to BCD serially, and drives five seven-segment digits.
module countdown_display
   import whac_display_pkg::*;
#(
   parameter int unsigned GAME_LENGTH_SECONDS = 20,
   parameter int unsigned REFRESH_CLKS        = 50000
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [$clog2(GAME_LENGTH_SECONDS)-1:0] count_down_seconds,
   input  logic [9:0]                             count_down_milliseconds,
   input  logic                                   blank,
   output logic [SEG_W-1:0]                       hex_sec_tens,
   output logic [SEG_W-1:0]                       hex_sec_ones,
   output logic [SEG_W-1:0]                       hex_ms_hund,
   output logic [SEG_W-1:0]                       hex_ms_tens,
   output logic [SEG_W-1:0]                       hex_ms_ones,
   output logic                                   time_up,
   output logic                                   frame_done
);

   localparam int unsigned CNT_W = $clog2(REFRESH_CLKS);

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  refresh_cnt;
   logic [ITER_W-1:0] iter_cnt;
   logic [DD_W-1:0]   sec_dd;
   logic [DD_W-1:0]   ms_dd;
   logic              cap_blank;
   logic              cap_zero;

   logic              tick_c;
   logic              last_step_c;
   logic              capture_c;
   logic              step_c;
   logic              load_c;
   logic [BIN_W-1:0]  remaining_ms_c;

   logic [3:0]        sec_tens_code_c;
   logic [3:0]        sec_ones_code_c;
   logic [3:0]        ms_hund_code_c;
   logic [3:0]        ms_tens_code_c;
   logic [3:0]        ms_ones_code_c;
   logic [SEG_W-1:0]  seg_sec_tens_c;
   logic [SEG_W-1:0]  seg_sec_ones_c;
   logic [SEG_W-1:0]  seg_ms_hund_c;
   logic [SEG_W-1:0]  seg_ms_tens_c;
   logic [SEG_W-1:0]  seg_ms_ones_c;

   assign tick_c      = (refresh_cnt == CNT_W'(REFRESH_CLKS - 1));
   assign last_step_c = (iter_cnt == ITER_W'(DABBLE_STEPS - 1));

   // Out-of-range millisecond inputs clamp the remaining time to zero.
   always_comb begin
      remaining_ms_c = '0;
      if (count_down_milliseconds <= BIN_W'(MS_PER_SECOND - 1))
         remaining_ms_c = BIN_W'(MS_PER_SECOND - 1) - count_down_milliseconds;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic; ticks outside IDLE are dropped
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (tick_c)      state_nxt = CONVERT;
         CONVERT: if (last_step_c) state_nxt = UPDATE;
         UPDATE:                   state_nxt = IDLE;
         default:                  state_nxt = IDLE;
      endcase
   end

   // State-decoded datapath controls
   always_comb begin
      capture_c = 1'b0;
      step_c    = 1'b0;
      load_c    = 1'b0;
      case (state)
         IDLE:    capture_c = tick_c;
         CONVERT: step_c    = 1'b1;
         UPDATE:  load_c    = 1'b1;
         default: ;
      endcase
   end

   // Leading seconds-tens zero is suppressed; blank darkens every digit.
   always_comb begin
      sec_tens_code_c = sec_dd[BIN_W + 4 +: 4];
      sec_ones_code_c = sec_dd[BIN_W +: 4];
      ms_hund_code_c  = ms_dd[BIN_W + 8 +: 4];
      ms_tens_code_c  = ms_dd[BIN_W + 4 +: 4];
      ms_ones_code_c  = ms_dd[BIN_W +: 4];
      if (sec_tens_code_c == 4'd0)
         sec_tens_code_c = DIGIT_OFF;
      if (cap_blank) begin
         sec_tens_code_c = DIGIT_OFF;
         sec_ones_code_c = DIGIT_OFF;
         ms_hund_code_c  = DIGIT_OFF;
         ms_tens_code_c  = DIGIT_OFF;
         ms_ones_code_c  = DIGIT_OFF;
      end
   end

   seg7_decoder u_dec_sec_tens (.digit(sec_tens_code_c), .seg_c(seg_sec_tens_c));
   seg7_decoder u_dec_sec_ones (.digit(sec_ones_code_c), .seg_c(seg_sec_ones_c));
   seg7_decoder u_dec_ms_hund  (.digit(ms_hund_code_c),  .seg_c(seg_ms_hund_c));
   seg7_decoder u_dec_ms_tens  (.digit(ms_tens_code_c),  .seg_c(seg_ms_tens_c));
   seg7_decoder u_dec_ms_ones  (.digit(ms_ones_code_c),  .seg_c(seg_ms_ones_c));

   // Refresh timer, capture, serial BCD conversion and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         refresh_cnt  <= '0;
         iter_cnt     <= '0;
         sec_dd       <= '0;
         ms_dd        <= '0;
         cap_blank    <= 1'b0;
         cap_zero     <= 1'b0;
         hex_sec_tens <= SEG_BLANK;
         hex_sec_ones <= SEG_BLANK;
         hex_ms_hund  <= SEG_BLANK;
         hex_ms_tens  <= SEG_BLANK;
         hex_ms_ones  <= SEG_BLANK;
         time_up      <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         refresh_cnt <= tick_c ? '0 : refresh_cnt + CNT_W'(1);
         frame_done  <= load_c;

         if (capture_c) begin
            sec_dd    <= {BCD_W'(0), BIN_W'(count_down_seconds)};
            ms_dd     <= {BCD_W'(0), remaining_ms_c};
            cap_blank <= blank;
            cap_zero  <= (count_down_seconds == '0) && (remaining_ms_c == '0);
            iter_cnt  <= '0;
         end else if (step_c) begin
            sec_dd   <= dabble_step(sec_dd);
            ms_dd    <= dabble_step(ms_dd);
            iter_cnt <= iter_cnt + ITER_W'(1);
         end

         if (load_c) begin
            hex_sec_tens <= seg_sec_tens_c;
            hex_sec_ones <= seg_sec_ones_c;
            hex_ms_hund  <= seg_ms_hund_c;
            hex_ms_tens  <= seg_ms_tens_c;
            hex_ms_ones  <= seg_ms_ones_c;
            time_up      <= cap_zero;
         end
      end
   end

endmodule

// File: tb/tb_countdown_display.sv
// Directed bench for countdown_display with a 16-clock refresh period.
module tb_countdown_display;

   localparam logic [6:0] D0 = 7'b1000000;
   localparam logic [6:0] D1 = 7'b1111001;
   localparam logic [6:0] D2 = 7'b0100100;
   localparam logic [6:0] D3 = 7'b0110000;
   localparam logic [6:0] D4 = 7'b0011001;
   localparam logic [6:0] D5 = 7'b0010010;
   localparam logic [6:0] D7 = 7'b1111000;
   localparam logic [6:0] D9 = 7'b0010000;
   localparam logic [6:0] OFF = 7'b1111111;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] count_down_seconds = '0;
   logic [9:0] count_down_milliseconds = '0;
   logic       blank = 1'b0;
   logic [6:0] hex_sec_tens, hex_sec_ones, hex_ms_hund, hex_ms_tens, hex_ms_ones;
   logic       time_up, frame_done;
   logic [34:0] disp;

   int passed = 0;
   int total  = 0;
   int cyc    = 0;

   countdown_display #(.GAME_LENGTH_SECONDS(20), .REFRESH_CLKS(16)) dut (
      .clk(clk), .rst(rst),
      .count_down_seconds(count_down_seconds),
      .count_down_milliseconds(count_down_milliseconds),
      .blank(blank),
      .hex_sec_tens(hex_sec_tens), .hex_sec_ones(hex_sec_ones),
      .hex_ms_hund(hex_ms_hund), .hex_ms_tens(hex_ms_tens), .hex_ms_ones(hex_ms_ones),
      .time_up(time_up), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // Edges since reset release; ticks land on multiples of 16.
   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   assign disp = {hex_sec_tens, hex_sec_ones, hex_ms_hund, hex_ms_tens, hex_ms_ones};

   task automatic wait_frame(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (frame_done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_phase(input int ph);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (cyc % 16 == ph) break;
      end
   endtask

   task automatic set_inputs(input logic [4:0] s, input logic [9:0] ms, input logic b);
      count_down_seconds      = s;
      count_down_milliseconds = ms;
      blank                   = b;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      set_inputs(5'd20, 10'd0, 1'b0);
      repeat (3) @(negedge clk);
      total++; if (disp !== {5{OFF}}) $display("FAIL reset_disp: got %b want %b", disp, {5{OFF}}); else passed++;
      total++; if (time_up !== 1'b0) $display("FAIL reset_time_up: got %b want 0", time_up); else passed++;
      total++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b want 0", frame_done); else passed++;
      rst = 1'b0;
   endtask

   task automatic test_sec20_ms0;
      bit ok;
      wait_frame(ok);
      total++; if (!ok) $display("FAIL sec20_timeout: got no frame_done want one"); else passed++;
      total++; if (cyc !== 27) $display("FAIL sec20_first_frame: got cycle %0d want 27", cyc); else passed++;
      total++; if (disp !== {D2, D0, D9, D9, D9}) $display("FAIL sec20_disp: got %b want %b", disp, {D2, D0, D9, D9, D9}); else passed++;
      total++; if (time_up !== 1'b0) $display("FAIL sec20_time_up: got %b want 0", time_up); else passed++;
      @(negedge clk);
      total++; if (frame_done !== 1'b0) $display("FAIL sec20_pulse_width: got %b want 0", frame_done); else passed++;
   endtask

   task automatic test_sec7_ms500;
      bit ok;
      set_inputs(5'd7, 10'd500, 1'b0);
      wait_frame(ok);
      total++; if (!ok || cyc % 16 != 11) $display("FAIL sec7_latency: got phase %0d want 11", cyc % 16); else passed++;
      total++; if (disp !== {OFF, D7, D4, D9, D9}) $display("FAIL sec7_disp: got %b want %b", disp, {OFF, D7, D4, D9, D9}); else passed++;
      total++; if (time_up !== 1'b0) $display("FAIL sec7_time_up: got %b want 0", time_up); else passed++;
   endtask

   task automatic test_time_up;
      bit ok;
      set_inputs(5'd0, 10'd999, 1'b0);
      wait_frame(ok);
      total++; if (!ok || cyc % 16 != 11) $display("FAIL tu_latency: got phase %0d want 11", cyc % 16); else passed++;
      total++; if (disp !== {OFF, D0, D0, D0, D0}) $display("FAIL tu_disp: got %b want %b", disp, {OFF, D0, D0, D0, D0}); else passed++;
      total++; if (time_up !== 1'b1) $display("FAIL tu_time_up: got %b want 1", time_up); else passed++;
   endtask

   task automatic test_clamp;
      bit ok;
      set_inputs(5'd3, 10'd1005, 1'b0);
      wait_frame(ok);
      total++; if (!ok || cyc % 16 != 11) $display("FAIL clamp_latency: got phase %0d want 11", cyc % 16); else passed++;
      total++; if (disp !== {OFF, D3, D0, D0, D0}) $display("FAIL clamp_disp: got %b want %b", disp, {OFF, D3, D0, D0, D0}); else passed++;
      total++; if (time_up !== 1'b0) $display("FAIL clamp_time_up: got %b want 0", time_up); else passed++;
   endtask

   task automatic test_blank;
      bit ok;
      set_inputs(5'd0, 10'd1000, 1'b1);
      wait_frame(ok);
      total++; if (!ok || cyc % 16 != 11) $display("FAIL blank_latency: got phase %0d want 11", cyc % 16); else passed++;
      total++; if (disp !== {5{OFF}}) $display("FAIL blank_disp: got %b want %b", disp, {5{OFF}}); else passed++;
      total++; if (time_up !== 1'b1) $display("FAIL blank_time_up: got %b want 1", time_up); else passed++;
   endtask

   task automatic test_mid_convert;
      bit ok;
      set_inputs(5'd15, 10'd250, 1'b0);
      wait_phase(3);
      total++; if (disp !== {5{OFF}} || time_up !== 1'b1) $display("FAIL hold_outputs: got %b/%b want %b/1", disp, time_up, {5{OFF}}); else passed++;
      set_inputs(5'd9, 10'd0, 1'b1);
      wait_frame(ok);
      total++; if (!ok || cyc % 16 != 11) $display("FAIL midconv_latency: got phase %0d want 11", cyc % 16); else passed++;
      total++; if (disp !== {D1, D5, D7, D4, D9}) $display("FAIL midconv_disp: got %b want %b", disp, {D1, D5, D7, D4, D9}); else passed++;
      total++; if (time_up !== 1'b0) $display("FAIL midconv_time_up: got %b want 0", time_up); else passed++;
      wait_frame(ok);
      total++; if (!ok || disp !== {5{OFF}}) $display("FAIL midconv_next_disp: got %b want %b", disp, {5{OFF}}); else passed++;
   endtask

   task automatic test_reset_mid_convert;
      bit ok;
      set_inputs(5'd10, 10'd0, 1'b0);
      wait_frame(ok);
      total++; if (!ok || disp !== {D1, D0, D9, D9, D9}) $display("FAIL sec10_disp: got %b want %b", disp, {D1, D0, D9, D9, D9}); else passed++;
      set_inputs(5'd20, 10'd0, 1'b0);
      wait_phase(5);
      total++; if (disp !== {D1, D0, D9, D9, D9}) $display("FAIL rstmid_hold: got %b want %b", disp, {D1, D0, D9, D9, D9}); else passed++;
      rst = 1'b1;
      @(negedge clk);
      total++; if (disp !== {5{OFF}}) $display("FAIL rstmid_disp: got %b want %b", disp, {5{OFF}}); else passed++;
      total++; if (time_up !== 1'b0 || frame_done !== 1'b0) $display("FAIL rstmid_flags: got %b%b want 00", time_up, frame_done); else passed++;
      rst = 1'b0;
      wait_frame(ok);
      total++; if (!ok || cyc !== 27) $display("FAIL rstmid_first_frame: got cycle %0d want 27", cyc); else passed++;
      total++; if (disp !== {D2, D0, D9, D9, D9}) $display("FAIL rstmid_next_disp: got %b want %b", disp, {D2, D0, D9, D9, D9}); else passed++;
   endtask

   initial begin
      test_reset();
      test_sec20_ms0();
      test_sec7_ms500();
      test_time_up();
      test_clamp();
      test_blank();
      set_inputs(5'd15, 10'd250, 1'b0);
      test_mid_convert();
      test_reset_mid_convert();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/countdown_display.md
COUNTDOWN_DISPLAY -- requirements
Module: countdown_display

Interface
REQ-001 SHALL have parameter GAME_LENGTH_SECONDS, default 20, which is the seconds range (at most 99).
REQ-002 SHALL have parameter REFRESH_CLKS, default 50000, which is the clocks between display samples (at least 16).
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1 bit: system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port count_down_seconds, input, $clog2(GAME_LENGTH_SECONDS) bits: remaining whole seconds from the game timer.
REQ-007 SHALL have port count_down_milliseconds, input, 10 bits: elapsed ms within the current second (0..999) from the game timer.
REQ-008 SHALL have port blank, input, 1 bit: force all digits off.
REQ-009 SHALL have ports hex_sec_tens and hex_sec_ones, output, 7 bits each: active-low segments {g,f,e,d,c,b,a}.
REQ-010 SHALL have ports hex_ms_hund, hex_ms_tens and hex_ms_ones, output, 7 bits each: active-low segments {g,f,e,d,c,b,a}.
REQ-011 SHALL have port time_up, output, 1 bit: the last sample showed 0.000.
REQ-012 SHALL have port frame_done, output, 1 bit: one-cycle pulse when the outputs refresh.

Function
REQ-013 SHALL run a free-running refresh counter 0..REFRESH_CLKS-1; a sample tick occurs when it equals REFRESH_CLKS-1.
REQ-014 SHALL use FSM states IDLE, CONVERT and UPDATE: IDLE->CONVERT on tick; CONVERT->UPDATE after 10 iterations; UPDATE->IDLE unconditionally.
REQ-015 SHALL ignore a tick outside IDLE, with no queuing.
REQ-016 SHALL, on the tick edge in IDLE, capture count_down_seconds (zero-extended to 10 bits) and remaining_ms = 999 - count_down_milliseconds.
REQ-017 SHALL clamp remaining_ms to 0 when count_down_milliseconds > 999.
REQ-018 SHALL capture blank on the same edge as REQ-016.
REQ-019 SHALL, in CONVERT, perform one double-dabble step per cycle on seconds and ms in parallel: add 3 to each BCD nibble >= 5, then shift left by 1; exactly 10 steps, tracked by a 4-bit iteration counter.
REQ-020 SHALL, in UPDATE, register all five segment outputs and time_up and pulse frame_done high for exactly this cycle.
REQ-021 SHALL have a latency of 11 cycles: outputs and frame_done change on the 11th rising edge after the tick edge.
REQ-022 SHALL suppress a leading seconds-tens zero to 7'b1111111; seconds ones and all ms digits always display, including zeros.
REQ-023 SHALL drive every digit to 7'b1111111 when the captured blank=1, with time_up still computed.
REQ-024 SHALL set time_up = 1 when captured seconds == 0 and remaining_ms == 0, else 0.
REQ-025 SHALL hold outputs between UPDATE cycles; inputs changing mid-CONVERT SHALL NOT affect the frame in progress.

Reset
REQ-026 SHALL, on rst=1 at a rising edge, put the FSM in IDLE and zero the refresh counter, iteration counter and BCD registers.
REQ-027 SHALL, on reset, drive all hex outputs to 7'b1111111 and time_up and frame_done to 0.
REQ-028 SHALL apply REQ-026 and REQ-027 when rst is asserted mid-CONVERT, with the frame aborted and no frame_done.
REQ-029 SHALL produce its first tick REFRESH_CLKS cycles after rst deasserts.

Structure
REQ-030 SHALL place in a shared package whac_display_pkg: the FSM state typedef, SEG_BLANK = 7'b1111111, MS_PER_SECOND = 1000 and DABBLE_STEPS = 10.
REQ-031 SHALL implement BCD-to-segment decoding in one combinational sub-module, seg7_decoder, instantiated five times; digit codes above 9 decode to blank.
REQ-032 SHALL include no other sub-modules.

Verification (REFRESH_CLKS=16, GAME_LENGTH_SECONDS=20)
REQ-033 SHALL cover: seconds=20, ms=0 -> sec 7'b0100100/7'b1000000, ms digits all 7'b0010000 (999), time_up=0, frame_done 11 cycles after tick.
REQ-034 SHALL cover: seconds=7, ms=500 -> sec tens 7'b1111111, ones 7'b1111000, ms shows 499 (7'b0011001, 7'b0010000, 7'b0010000).
REQ-035 SHALL cover: seconds=0, ms=999 -> sec tens blank, ones 7'b1000000, ms 000 (all 7'b1000000), time_up=1.
REQ-036 SHALL cover: ms=1005 -> ms shows 000 (clamp).
REQ-037 SHALL cover: blank=1 at tick -> all five outputs 7'b1111111 next frame.
REQ-038 SHALL cover: inputs changed during CONVERT -> frame matches the captured values.
REQ-039 SHALL cover: rst asserted during CONVERT iteration 5 -> outputs 7'b1111111, no frame_done, next frame_done exactly 16+11 cycles after rst deasserts.
